// File: rtl/level_cls_pkg.sv
// Shared zone and framing-state encodings for the level classifier front end.
package level_cls_pkg;

  typedef enum logic [1:0] {
    Z_LOW  = 2'd0,
    Z_MID  = 2'd1,
    Z_HIGH = 2'd2
  } zone_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_END    = 2'd2
  } state_t;

  // Returns {high, mid, low} so the level flags stay one-hot by construction.
  function automatic logic [2:0] zone_onehot(zone_t z);
    case (z)
      Z_MID:   zone_onehot = 3'b010;
      Z_HIGH:  zone_onehot = 3'b100;
      default: zone_onehot = 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/lvl_debounce.sv
// Commits a new zone only after STABLE_CNT valid samples agree on it;
// non-valid cycles freeze the candidate and its count.
module lvl_debounce
  import level_cls_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  vld,
  input  zone_t raw,
  output zone_t zone,
  output zone_t zone_nxt,
  output logic  commit
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  zone_t         cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt, hits;

  always_comb begin
    zone_nxt = zone;
    cand_nxt = cand;
    cnt_nxt  = cnt;
    commit   = 1'b0;
    hits     = '0;
    if (vld) begin
      if (raw == zone) begin
        cnt_nxt = '0;
      end else begin
        // a sample that disagrees with the candidate restarts the run at one
        hits     = (raw == cand) ? cnt + 1'b1 : CW'(1);
        cand_nxt = raw;
        if (hits >= CW'(STABLE_CNT)) begin
          commit   = 1'b1;
          zone_nxt = raw;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = hits;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zone <= Z_LOW;
      cand <= Z_LOW;
      cnt  <= '0;
    end else begin
      zone <= zone_nxt;
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/level_classifier.sv
// Sample-stream front end: hysteresis level classification plus enable/timeout framing.
// Optional build macro LEVEL_CLASSIFIER_STATS_EN adds the zone_changes frame counter.
module level_classifier
  import level_cls_pkg::*;
#(
  parameter int DW           = 8,
  parameter int TH_LOW       = 64,
  parameter int TH_HIGH      = 192,
  parameter int HYST         = 8,
  parameter int STABLE_CNT   = 3,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sample_vld,
  input  logic [DW-1:0] sample,
  output logic          start,
  output logic          sfarsit,
  output logic          jos,
  output logic          mijloc,
  output logic          sus,
`ifdef LEVEL_CLASSIFIER_STATS_EN
  output logic [7:0]    zone_changes,
`endif
  output logic          busy
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  // One extra bit keeps threshold +/- hysteresis from wrapping.
  localparam logic [DW:0] LOW_UP  = (DW+1)'(TH_LOW + HYST);
  localparam logic [DW:0] LOW_DN  = (DW+1)'(TH_LOW - HYST);
  localparam logic [DW:0] HIGH_UP = (DW+1)'(TH_HIGH + HYST);
  localparam logic [DW:0] HIGH_DN = (DW+1)'(TH_HIGH - HYST);

  logic [DW:0]   sx;
  zone_t         raw, cur, cur_nxt;
  logic          commit;
  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          start_nxt, sfarsit_nxt;

  assign sx = {1'b0, sample};

  always_comb begin
    raw = cur;
    case (cur)
      Z_LOW: begin
        if (sx > HIGH_UP)      raw = Z_HIGH;
        else if (sx >= LOW_UP) raw = Z_MID;
        else                   raw = Z_LOW;
      end
      Z_MID: begin
        if (sx < LOW_DN)       raw = Z_LOW;
        else if (sx > HIGH_UP) raw = Z_HIGH;
        else                   raw = Z_MID;
      end
      Z_HIGH: begin
        if (sx < LOW_DN)        raw = Z_LOW;
        else if (sx <= HIGH_DN) raw = Z_MID;
        else                    raw = Z_HIGH;
      end
      default: raw = Z_LOW;
    endcase
  end

  lvl_debounce #(.STABLE_CNT(STABLE_CNT)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .vld      (sample_vld),
    .raw      (raw),
    .zone     (cur),
    .zone_nxt (cur_nxt),
    .commit   (commit)
  );

  // Disable or timeout closes the frame even when a sample arrives the same cycle.
  always_comb begin
    state_nxt   = state;
    to_nxt      = to_cnt;
    start_nxt   = 1'b0;
    sfarsit_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        to_nxt = '0;
        if (en && sample_vld) begin
          state_nxt = S_ACTIVE;
          start_nxt = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (sample_vld)                         to_nxt = '0;
        else if (to_cnt != TW'(IDLE_TIMEOUT))   to_nxt = to_cnt + 1'b1;
        if (!en || to_nxt == TW'(IDLE_TIMEOUT)) begin
          state_nxt   = S_END;
          sfarsit_nxt = 1'b1;
          to_nxt      = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        to_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      to_cnt            <= '0;
      start             <= 1'b0;
      sfarsit           <= 1'b0;
      busy              <= 1'b0;
      {sus, mijloc, jos} <= 3'b001;
    end else begin
      state             <= state_nxt;
      to_cnt            <= to_nxt;
      start             <= start_nxt;
      sfarsit           <= sfarsit_nxt;
      busy              <= (state_nxt == S_ACTIVE);
      {sus, mijloc, jos} <= zone_onehot(cur_nxt);
    end
  end

`ifdef LEVEL_CLASSIFIER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start_nxt)
      zone_changes <= '0;
    else if (state == S_ACTIVE && commit && zone_changes != 8'hFF)
      zone_changes <= zone_changes + 8'd1;
  end
`endif

endmodule

// File: tb/tb_level_classifier.sv
// Randomized bench for level_classifier: a behavioural model queues expected
// outputs each clock, an independent monitor pops and compares them.
module tb_level_classifier;

  localparam int TL = 64;
  localparam int TH = 192;
  localparam int H  = 8;
  localparam int SC = 3;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sample_vld = 1'b0;
  logic [7:0] sample = '0;
  logic       start, sfarsit, jos, mijloc, sus, busy;
`ifdef LEVEL_CLASSIFIER_STATS_EN
  logic [7:0] zone_changes;
`endif

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];

  level_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_vld   (sample_vld),
    .sample       (sample),
    .start        (start),
    .sfarsit      (sfarsit),
    .jos          (jos),
    .mijloc       (mijloc),
    .sus          (sus),
`ifdef LEVEL_CLASSIFIER_STATS_EN
    .zone_changes (zone_changes),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: levels 0/1/2, frame tracked as plain flags and counters.
  int m_cur = 0, m_cand = 0, m_run = 0, m_idle = 0;
  bit m_in_frame = 0, m_closing = 0, m_start = 0, m_end = 0;

  function automatic int raw_zone(int s, int cur);
    if (cur == 0) return (s > TH + H) ? 2 : ((s >= TL + H) ? 1 : 0);
    if (cur == 1) return (s < TL - H) ? 0 : ((s > TH + H) ? 2 : 1);
    return (s < TL - H) ? 0 : ((s <= TH - H) ? 1 : 2);
  endfunction

  always @(posedge clk) begin
    int r;
    if (rst) begin
      m_cur = 0; m_cand = 0; m_run = 0; m_idle = 0;
      m_in_frame = 0; m_closing = 0; m_start = 0; m_end = 0;
    end else begin
      m_start = 0;
      m_end   = 0;
      if (m_closing) begin
        m_closing = 0;
      end else if (!m_in_frame) begin
        if (en && sample_vld) begin
          m_in_frame = 1; m_start = 1; m_idle = 0;
        end
      end else begin
        m_idle = sample_vld ? 0 : ((m_idle < TO) ? m_idle + 1 : TO);
        if (!en || m_idle == TO) begin
          m_in_frame = 0; m_closing = 1; m_end = 1; m_idle = 0;
        end
      end
      if (sample_vld) begin
        r = raw_zone(int'(sample), m_cur);
        if (r == m_cur) m_run = 0;
        else if (r == m_cand) m_run = m_run + 1;
        else begin m_cand = r; m_run = 1; end
        if (m_run >= SC) begin m_cur = r; m_run = 0; end
      end
    end
    exp_q.push_back({m_cur == 0, m_cur == 1, m_cur == 2, m_start, m_end, m_in_frame});
  end

  task automatic checkOutput(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got {jos,mijloc,sus,start,sfarsit,busy}=%b want=%b",
               name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("scoreboard", {jos, mijloc, sus, start, sfarsit, busy}, e);
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic v, input logic [7:0] s);
    rst = r; en = e; sample_vld = v; sample = s;
    @(negedge clk);
  endtask

  task automatic randCycle(input logic v, input logic [7:0] s);
    logic r;
    if ($urandom_range(0, 39) == 0) en = ~en;
    r = ($urandom_range(0, 499) == 0);
    applyStimulus(r, en, v, s);
  endtask

  function automatic logic [5:0] outs();
    return {jos, mijloc, sus, start, sfarsit, busy};
  endfunction

  logic [7:0] edges [12] = '{55, 56, 57, 71, 72, 73, 183, 184, 185, 199, 200, 201};

  initial begin
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset", outs(), 6'b100000);

    applyStimulus(0, 0, 1, 100);
    applyStimulus(0, 0, 1, 100);
    applyStimulus(0, 0, 1, 30);
    checkOutput("deb_interrupted", outs(), 6'b100000);

    applyStimulus(0, 0, 1, 100);
    repeat (5) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 100);
    checkOutput("deb_gap_pending", outs(), 6'b100000);
    applyStimulus(0, 0, 1, 100);
    checkOutput("deb_gap_commit", outs(), 6'b010000);

    repeat (3) applyStimulus(0, 0, 1, 60);
    checkOutput("hyst_mid_hold", outs(), 6'b010000);
    repeat (3) applyStimulus(0, 0, 1, 55);
    checkOutput("hyst_to_low", outs(), 6'b100000);
    repeat (3) applyStimulus(0, 0, 1, 200);
    checkOutput("low_200_mid", outs(), 6'b010000);
    repeat (3) applyStimulus(0, 0, 1, 201);
    checkOutput("mid_201_high", outs(), 6'b001000);
    repeat (3) applyStimulus(0, 0, 1, 100);
    checkOutput("high_to_mid", outs(), 6'b010000);

    // timeout framing
    applyStimulus(1, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 30);
    checkOutput("frame_start", outs(), 6'b100101);
    applyStimulus(0, 1, 0, 0);
    checkOutput("start_one_cycle", outs(), 6'b100001);
    repeat (14) applyStimulus(0, 1, 0, 0);
    checkOutput("before_timeout", outs(), 6'b100001);
    applyStimulus(0, 1, 0, 0);
    checkOutput("timeout_end", outs(), 6'b100010);
    applyStimulus(0, 1, 1, 30);
    checkOutput("no_start_in_end", outs(), 6'b100000);
    applyStimulus(0, 1, 1, 30);
    checkOutput("restart", outs(), 6'b100101);

    // en drop with sample: end wins, sample still debounced
    applyStimulus(0, 1, 1, 100);
    applyStimulus(0, 1, 1, 100);
    applyStimulus(0, 0, 1, 100);
    checkOutput("simul_end", outs(), 6'b010010);

    // reset mid-frame, mid-debounce
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 201);
    applyStimulus(0, 1, 1, 201);
    applyStimulus(1, 1, 0, 0);
    checkOutput("reset_midframe", outs(), 6'b100000);
    applyStimulus(0, 1, 0, 0);
    checkOutput("no_end_after_rst", outs(), 6'b100000);

    // randomized runs of repeated samples with variable gaps
    for (int run = 0; run < 400; run++) begin
      logic [7:0] val;
      int len, dense, gap;
      val   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : edges[$urandom_range(0, 11)];
      len   = $urandom_range(1, 5);
      dense = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < len; k++) begin
        gap = dense ? $urandom_range(0, 1) : $urandom_range(0, 20);
        for (int g = 0; g < gap; g++) randCycle(0, 8'($urandom_range(0, 255)));
        randCycle(1, val);
      end
    end

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    $display("[TB] done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
